ixc_sv_sfifo_writer: RTL and testbench

//  Producer end of the SV streaming FIFO channel: takes DATA_W-bit words from DUT-side

---
 rtl/ixc_sv_sfifo_writer.sv | 72 +++++++
 tb/tb_ixc_sv_sfifo_writer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ixc_sv_sfifo_writer.sv
// ixc_sv_sfifo_writer: producer end of the SV streaming FIFO channel; buffers DUT words
// and forwards them to the transport under host read-count window flow control.
module ixc_sv_sfifo_writer #(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 16,
  parameter int WINDOW = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              wr_vld,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_rdy,
  input  logic              flush_req,
  output logic              flush_done,
  output logic              xp_vld,
  output logic [DATA_W-1:0] xp_data,
  input  logic              xp_rdy,
  input  logic [63:0]       rd_cnt,
  output logic [63:0]       wr_cnt,
  output logic [63:0]       xp_cnt,
  output logic [AW:0]       level,
  output logic              cnt_err
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t stateQ, stateD;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [63:0] inFlight, pending;
  logic push, load, ahead, creditOk, drained;
  assign inFlight = xp_cnt - rd_cnt;
  assign ahead    = inFlight[63];
  // the word sitting in xp_data is counted too, so the window never overshoots
  assign pending  = inFlight + 64'(xp_vld);
  assign creditOk = !ahead && pending < 64'(WINDOW);
  assign wr_rdy   = stateQ == RUN && level < (AW+1)'(DEPTH) && !flush_req;
  assign push     = wr_vld && wr_rdy;
  assign load     = (!xp_vld || xp_rdy) && level != 0 && creditOk && stateQ != IDLE;
  assign drained  = level == 0 && !xp_vld;
  assign flush_done = stateQ == DRAIN && drained;
  always_comb begin
    stateD = stateQ;
    stateD = stateQ == IDLE ? (enable ? RUN : IDLE) :
             stateQ == RUN  ? (flush_req ? DRAIN : enable ? RUN : IDLE) :
             drained        ? (enable ? RUN : IDLE) : DRAIN;
  end
  always_ff @(posedge clk) if (push) mem[wrPtr] <= wr_data;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ  <= IDLE;
      wrPtr   <= '0;
      rdPtr   <= '0;
      level   <= '0;
      xp_vld  <= 1'b0;
      xp_data <= '0;
      wr_cnt  <= '0;
      xp_cnt  <= '0;
      cnt_err <= 1'b0;
    end else begin
      stateQ  <= stateD;
      wrPtr   <= wrPtr + AW'(push);
      rdPtr   <= rdPtr + AW'(load);
      level   <= level + (AW+1)'(push) - (AW+1)'(load);
      xp_vld  <= load || (xp_vld && !xp_rdy);
      xp_data <= load ? mem[rdPtr] : xp_data;
      wr_cnt  <= wr_cnt + 64'(push);
      xp_cnt  <= xp_cnt + 64'(xp_vld && xp_rdy);
      cnt_err <= cnt_err || ahead;
    end
  end
endmodule

// File: tb/tb_ixc_sv_sfifo_writer.sv
// tb_ixc_sv_sfifo_writer: directed checks of intake, delivery order, window credit,
// flush, count-error and counter wrap for the streaming FIFO writer.
module tb_ixc_sv_sfifo_writer;
  logic clk = 0, rst_n = 0, enable = 0, wr_vld = 0, wr_rdy, flush_req = 0, flush_done;
  logic xp_vld, xp_rdy = 0, cnt_err;
  logic [255:0] wr_data = '0, xp_data;
  logic [63:0] rd_cnt = '0, wr_cnt, xp_cnt;
  logic [4:0] level;
  int nChk = 0, nPass = 0;
  int accCnt, gotCnt, doneCnt, feedMax;
  logic [255:0] feedBase, gotBase;
  bit track;

  ixc_sv_sfifo_writer dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr_vld(wr_vld), .wr_data(wr_data),
    .wr_rdy(wr_rdy), .flush_req(flush_req), .flush_done(flush_done), .xp_vld(xp_vld),
    .xp_data(xp_data), .xp_rdy(xp_rdy), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt),
    .xp_cnt(xp_cnt), .level(level), .cnt_err(cnt_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    nChk++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
    if (track) rd_cnt = xp_cnt;
  endtask

  task automatic reset_dut;
    rst_n = 0; enable = 0; wr_vld = 0; flush_req = 0; xp_rdy = 0; track = 0; rd_cnt = '0;
    step;
    step;
    rst_n = 1;
    accCnt = 0; gotCnt = 0; doneCnt = 0; feedMax = 0;
  endtask

  task automatic open_channel;
    enable = 1;
    step;
  endtask

  // feeds words feedBase+n until feedMax accepted; checks delivered order from gotBase
  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      wr_vld = accCnt < feedMax;
      wr_data = feedBase + 256'(accCnt);
      if (wr_vld && wr_rdy) accCnt++;
      if (xp_vld && xp_rdy) begin
        check("order", xp_data, gotBase + 256'(gotCnt));
        gotCnt++;
      end
      if (flush_done) doneCnt++;
      step;
    end
    wr_vld = 0;
  endtask

  task automatic check_reset_state;
    check("rst_wr_rdy", 256'(wr_rdy), 0);
    check("rst_xp_vld", 256'(xp_vld), 0);
    check("rst_xp_data", xp_data, 0);
    check("rst_flush_done", 256'(flush_done), 0);
    check("rst_wr_cnt", 256'(wr_cnt), 0);
    check("rst_xp_cnt", 256'(xp_cnt), 0);
    check("rst_level", 256'(level), 0);
    check("rst_cnt_err", 256'(cnt_err), 0);
  endtask

  initial begin
    // basic flow and first-word latency
    reset_dut;
    check_reset_state;
    open_channel;
    check("run_rdy", 256'(wr_rdy), 1);
    xp_rdy = 1; track = 1;
    for (int i = 0; i < 4; i++) begin
      wr_vld = 1;
      wr_data = 256'h0A0 + 256'(i);
      step;
      if (i == 0) check("latency", 256'(xp_vld), 0);
      else check("b2b_data", xp_data, 256'h0A0 + 256'(i - 1));
    end
    wr_vld = 0;
    step;
    check("last_data", xp_data, 256'h0A3);
    check("last_vld", 256'(xp_vld), 1);
    step;
    check("idle_vld", 256'(xp_vld), 0);
    check("t1_wr_cnt", 256'(wr_cnt), 4);
    check("t1_xp_cnt", 256'(xp_cnt), 4);

    // fill: 16 buffered plus one held in the output register
    reset_dut;
    open_channel;
    track = 1; feedMax = 30; feedBase = 256'h100; gotBase = 256'h100;
    run(25);
    check("full_acc", 256'(accCnt), 17);
    check("full_level", 256'(level), 16);
    check("full_rdy", 256'(wr_rdy), 0);
    check("full_hold", xp_data, 256'h100);
    feedMax = accCnt; xp_rdy = 1;
    run(30);
    check("full_got", 256'(gotCnt), 17);

    // window limit with rd_cnt held at zero
    reset_dut;
    open_channel;
    xp_rdy = 1; feedMax = 80; feedBase = 256'h200; gotBase = 256'h200;
    run(120);
    check("win_xp_cnt", 256'(xp_cnt), 64);
    check("win_vld", 256'(xp_vld), 0);
    check("win_acc", 256'(accCnt), 80);
    rd_cnt = 64'd10;
    run(30);
    check("win_more", 256'(gotCnt), 74);
    check("win_xp_cnt2", 256'(xp_cnt), 74);
    check("win_level", 256'(level), 6);

    // flush with intake pending
    reset_dut;
    open_channel;
    track = 1; feedMax = 6; feedBase = 256'h300; gotBase = 256'h300;
    run(10);
    check("fl_level", 256'(level), 5);
    check("fl_hold", 256'(xp_vld), 1);
    wr_vld = 1; wr_data = 256'hDEAD; flush_req = 1;
    #1;
    check("fl_rdy_now", 256'(wr_rdy), 0);
    step;
    flush_req = 0;
    check("fl_rdy_drain", 256'(wr_rdy), 0);
    wr_vld = 0;
    check("fl_no_accept", 256'(wr_cnt), 6);
    xp_rdy = 1; feedMax = accCnt;
    run(20);
    check("fl_got", 256'(gotCnt), 6);
    check("fl_done_once", 256'(doneCnt), 1);
    check("fl_back_run", 256'(wr_rdy), 1);

    // rd_cnt ahead of xp_cnt, then reset clears everything
    reset_dut;
    open_channel;
    track = 1; xp_rdy = 1; feedMax = 3; feedBase = 256'h400; gotBase = 256'h400;
    run(8);
    check("err_pre", 256'(cnt_err), 0);
    track = 0; rd_cnt = xp_cnt + 64'd1;
    feedMax = 6;
    run(1);
    check("err_set", 256'(cnt_err), 1);
    run(6);
    check("err_noload", 256'(gotCnt), 3);
    check("err_vld", 256'(xp_vld), 0);
    check("err_level", 256'(level), 3);
    rst_n = 0;
    step;
    check_reset_state;
    rst_n = 1;

    // counter wrap; rd_cnt held below the wrap point
    reset_dut;
    open_channel;
    rd_cnt = 64'hFFFF_FFFF_FFFF_FFFE;
    force dut.wr_cnt = 64'hFFFF_FFFF_FFFF_FFFE;
    force dut.xp_cnt = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    release dut.wr_cnt;
    release dut.xp_cnt;
    xp_rdy = 1; feedMax = 3; feedBase = 256'h500; gotBase = 256'h500;
    run(10);
    check("wrap_wr_cnt", 256'(wr_cnt), 1);
    check("wrap_xp_cnt", 256'(xp_cnt), 1);
    check("wrap_got", 256'(gotCnt), 3);
    check("wrap_no_err", 256'(cnt_err), 0);

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end
endmodule
